// File: rtl/vga_timing_gen_if.sv
// Pixel-buffer read port of the VGA timing generator.
// The timing generator drives the coordinate and strobe.
// The frame buffer answers with colour data a fixed number of clocks later.
interface vga_timing_gen_if #(
  parameter int CW      = 10,
  parameter int COLOR_W = 8
);
  logic [CW-1:0]      outX;
  logic [CW-1:0]      outY;
  logic               outRequest;
  logic [COLOR_W-1:0] inRed;
  logic [COLOR_W-1:0] inGreen;
  logic [COLOR_W-1:0] inBlue;

  modport master (output outX, outY, outRequest, input inRed, inGreen, inBlue);
  modport slave  (input outX, outY, outRequest, output inRed, inGreen, inBlue);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-buffer request port and test patterns.
// Stage 0 is combinational from the raster counters.
// A delay line matches the buffer read latency.
// The DAC-side registers form the final stage.
module vga_timing_gen #(
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_DISPLAY = 640,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_DISPLAY = 480,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int RD_LAT    = 1,
  parameter int CW        = 10,
  parameter int COLOR_W   = 8
) (
  input  logic               clk25,
  input  logic               rstN,
  input  logic [1:0]         mode,
  vga_timing_gen_if.master   pixBus,
  output logic               frameStart,
  output logic               lineStart,
  output logic [COLOR_W-1:0] outRed,
  output logic [COLOR_W-1:0] outGreen,
  output logic [COLOR_W-1:0] outBlue,
  output logic               hs,
  output logic               vs,
  output logic               vgaClk,
  output logic               vgaBlankN,
  output logic               vgaSyncN
);
  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_DISPLAY;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int V_TOTAL = V_BLANK + V_DISPLAY;
  localparam int BAR_W   = H_DISPLAY / 8;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BLANK_C = CW'(H_BLANK);
  localparam logic [CW-1:0] V_BLANK_C = CW'(V_BLANK);
  localparam logic [CW-1:0] HS_START  = CW'(H_FRONT);
  localparam logic [CW-1:0] HS_END    = CW'(H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_FRONT);
  localparam logic [CW-1:0] VS_END    = CW'(V_FRONT + V_SYNC);

  if (RD_LAT < 0 || RD_LAT > 4) begin : gBadLat
    $error("vga_timing_gen: RD_LAT must be within 0..4");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CW) || longint'(V_TOTAL) > (longint'(1) << CW)) begin : gBadCw
    $error("vga_timing_gen: CW too narrow for the raster totals");
  end
  if (CW < 6 || H_DISPLAY < 8) begin : gBadGeom
    $error("vga_timing_gen: checkerboard needs CW>=6 and colour bars need H_DISPLAY>=8");
  end

  // Control travels separately from data so only control needs a reset.
  typedef struct packed {
    logic vld;
    logic hsy;
    logic vsy;
  } ctl_t;

  // Y only matters downstream through its checkerboard bit.
  typedef struct packed {
    logic [CW-1:0] x;
    logic          yChk;
    logic [1:0]    md;
  } dat_t;

  logic [CW-1:0] hCount, vCount;
  logic [CW-1:0] xPix0, yPix0;
  logic [1:0]    modeReg;
  ctl_t          ctl_p0, ctlTap;
  dat_t          dat_p0, datTap;

  function automatic logic [3*COLOR_W-1:0] pixelColour(input dat_t d,
                                                       input logic [3*COLOR_W-1:0] bufRgb);
    logic [2:0] bar;
    logic [3*COLOR_W-1:0] rgb;
    bar = 3'(d.x / CW'(BAR_W));
    case (d.md)
      2'd0:    rgb = bufRgb;
      2'd1:    rgb = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
      2'd2:    rgb = {(3*COLOR_W){d.x[5] ^ d.yChk}};
      default: rgb = {{COLOR_W{1'b1}}, {COLOR_W{1'b0}}, {COLOR_W{1'b1}}};
    endcase
    return rgb;
  endfunction

  // Raster counters: hCount wraps each line, vCount steps on the last pixel of a line.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == H_LAST) begin
      hCount <= '0;
      vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
    end else begin
      hCount <= hCount + 1'b1;
    end
  end

  assign frameStart = (hCount == H_BLANK_C) && (vCount == V_BLANK_C);
  assign lineStart  = (hCount == H_BLANK_C) && (vCount >= V_BLANK_C);

  // Mode is latched at the frame start so a frame never mixes sources.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) modeReg <= '0;
    else if (frameStart) modeReg <= mode;
  end

  // Stage 0: decode the raster position; the incoming mode applies on its first pixel.
  always_comb begin
    ctl_p0     = '0;
    dat_p0     = '0;
    xPix0      = '0;
    yPix0      = '0;
    ctl_p0.vld = (hCount >= H_BLANK_C) && (vCount >= V_BLANK_C);
    ctl_p0.hsy = (hCount >= HS_START) && (hCount < HS_END);
    ctl_p0.vsy = (vCount >= VS_START) && (vCount < VS_END);
    if (ctl_p0.vld) begin
      xPix0 = hCount - H_BLANK_C;
      yPix0 = vCount - V_BLANK_C;
    end
    dat_p0.x    = xPix0;
    dat_p0.yChk = yPix0[5];
    dat_p0.md   = frameStart ? mode : modeReg;
  end

  assign pixBus.outRequest = ctl_p0.vld;
  assign pixBus.outX       = xPix0;
  assign pixBus.outY       = yPix0;

  if (RD_LAT == 0) begin : gNoLat
    assign ctlTap = ctl_p0;
    assign datTap = dat_p0;
  end else begin : gLat
    ctl_t ctl_pN [1:RD_LAT];
    dat_t dat_pN [1:RD_LAT];

    // Stages 1..RD_LAT: control delay line, cleared on reset so nothing stale escapes.
    always_ff @(posedge clk25 or negedge rstN) begin
      if (!rstN) begin
        for (int i = 1; i <= RD_LAT; i++) ctl_pN[i] <= '0;
      end else begin
        ctl_pN[1] <= ctl_p0;
        for (int i = 2; i <= RD_LAT; i++) ctl_pN[i] <= ctl_pN[i-1];
      end
    end

    // Stages 1..RD_LAT: coordinate/mode delay line, aligned with buffer read data.
    always_ff @(posedge clk25) begin
      dat_pN[1] <= dat_p0;
      for (int i = 2; i <= RD_LAT; i++) dat_pN[i] <= dat_pN[i-1];
    end

    assign ctlTap = ctl_pN[RD_LAT];
    assign datTap = dat_pN[RD_LAT];
  end

  // Output stage: sync levels, blanking and colour are registered together.
  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      hs        <= ~H_POL;
      vs        <= ~V_POL;
      vgaBlankN <= 1'b0;
      {outRed, outGreen, outBlue} <= '0;
    end else begin
      hs        <= ctlTap.hsy ? H_POL : ~H_POL;
      vs        <= ctlTap.vsy ? V_POL : ~V_POL;
      vgaBlankN <= ctlTap.vld;
      {outRed, outGreen, outBlue} <= ctlTap.vld
        ? pixelColour(datTap, {pixBus.inRed, pixBus.inGreen, pixBus.inBlue})
        : '0;
    end
  end

  assign vgaClk   = ~clk25;
  assign vgaSyncN = 1'b1;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a reduced raster with a delayed buffer model.
module tb_vga_timing_gen;
  localparam int HF = 4, HSW = 6, HBK = 5, HD = 64;
  localparam int VF = 2, VSW = 2, VBK = 3, VD = 40;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int LAT = 2, CW = 8, COLW = 8;
  localparam int HB = HF + HSW + HBK, HT = HB + HD;
  localparam int VB = VF + VSW + VBK, VT = VB + VD;
  localparam int FRAME = HT * VT;
  localparam int L = LAT + 1;

  logic clk25 = 1'b0;
  logic rstN  = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] nextMode = 2'd0;
  logic frameStart, lineStart, hs, vs, vgaClk, vgaBlankN, vgaSyncN;
  logic [COLW-1:0] outRed, outGreen, outBlue;

  vga_timing_gen_if #(.CW(CW), .COLOR_W(COLW)) pixBus();

  vga_timing_gen #(
    .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBK), .H_DISPLAY(HD),
    .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBK), .V_DISPLAY(VD),
    .H_POL(HP), .V_POL(VP), .RD_LAT(LAT), .CW(CW), .COLOR_W(COLW)
  ) dut (
    .clk25(clk25), .rstN(rstN), .mode(mode), .pixBus(pixBus),
    .frameStart(frameStart), .lineStart(lineStart),
    .outRed(outRed), .outGreen(outGreen), .outBlue(outBlue),
    .hs(hs), .vs(vs), .vgaClk(vgaClk), .vgaBlankN(vgaBlankN), .vgaSyncN(vgaSyncN)
  );

  always #5 clk25 = ~clk25;

  // Clocks elapsed since reset release; equals the cycle index within the run.
  int cyc;
  always @(posedge clk25 or negedge rstN) begin
    if (!rstN) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    int due;
    logic hs, vs, bn;
    logic [3*COLW-1:0] rgb;
  } outExp_t;

  typedef struct {
    int at;
    logic req;
    logic [CW-1:0] x, y;
    logic fs, ls;
  } combExp_t;

  outExp_t  outQ[$];
  combExp_t combQ[$];
  logic [3*COLW-1:0] bufQ[$];
  int checks = 0;
  int errors = 0;
  bit monEn = 1'b0;
  int lastFs = -1;
  logic [1:0] mMode = 2'd0;
  logic [2:0] barTab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-buffer contents: every pixel holds a colour derived from its coordinate.
  function automatic logic [3*COLW-1:0] bufData(input int x, input int y);
    return {COLW'(x), COLW'(y), COLW'(x * 3 + y + 1)};
  endfunction

  function automatic logic [3*COLW-1:0] refColour(input logic [1:0] md, input int x, input int y);
    logic [2:0] c;
    logic [COLW-1:0] ones;
    ones = '1;
    case (md)
      2'd0: return bufData(x, y);
      2'd1: begin
        c = barTab[x / (HD / 8)];
        return {(c[2] ? ones : '0), (c[1] ? ones : '0), (c[0] ? ones : '0)};
      end
      2'd2: return ((((x / 32) + (y / 32)) % 2) == 1) ? {ones, ones, ones} : '0;
      default: return {ones, {COLW{1'b0}}, ones};
    endcase
  endfunction

  // One clock of stimulus: serve the buffer, apply mode, queue expected responses.
  task automatic stepCycle();
    int k, h, v;
    logic act;
    logic [3*COLW-1:0] d;
    outExp_t oe;
    combExp_t ce;
    @(negedge clk25);
    k = cyc;
    mode = nextMode;
    if (pixBus.outRequest) bufQ.push_back(bufData(int'(pixBus.outX), int'(pixBus.outY)));
    else begin
      d = (3*COLW)'($urandom);
      bufQ.push_back(d);
    end
    if (bufQ.size() > LAT) d = bufQ.pop_front();
    else d = (3*COLW)'($urandom);
    {pixBus.inRed, pixBus.inGreen, pixBus.inBlue} = d;

    h = k % HT;
    v = (k / HT) % VT;
    act = (h >= HB) && (v >= VB);
    if (h == HB && v == VB) mMode = mode;
    ce.at  = k;
    ce.req = act;
    ce.x   = act ? CW'(h - HB) : '0;
    ce.y   = act ? CW'(v - VB) : '0;
    ce.fs  = (h == HB) && (v == VB);
    ce.ls  = (h == HB) && (v >= VB);
    combQ.push_back(ce);
    oe.due = k + L;
    oe.hs  = (h >= HF && h < HF + HSW) ? HP : ~HP;
    oe.vs  = (v >= VF && v < VF + VSW) ? VP : ~VP;
    oe.bn  = act;
    oe.rgb = act ? refColour(mMode, h - HB, v - VB) : '0;
    outQ.push_back(oe);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic resetChecks(input string name);
    check({name, "-dac"}, 64'({hs, vs, vgaBlankN, outRed, outGreen, outBlue}),
          64'({~HP, ~VP, 1'b0, {(3*COLW){1'b0}}}));
    check({name, "-req"}, 64'({frameStart, lineStart, pixBus.outRequest, pixBus.outX, pixBus.outY}), 64'(0));
    check({name, "-clk"}, 64'({vgaClk, vgaSyncN}), 64'({~clk25, 1'b1}));
  endtask

  // Monitor: every clock the DUT presents outputs; pop the matching expectation.
  initial begin
    combExp_t ce;
    outExp_t oe;
    forever begin
      @(negedge clk25);
      #1;
      if (monEn) begin
        if (combQ.size() > 0 && combQ[0].at == cyc) begin
          ce = combQ.pop_front();
          check("request", 64'({pixBus.outRequest, pixBus.outX, pixBus.outY, frameStart, lineStart}),
                64'({ce.req, ce.x, ce.y, ce.fs, ce.ls}));
        end
        if (outQ.size() > 0 && outQ[0].due == cyc) oe = outQ.pop_front();
        else begin
          oe.due = cyc;
          oe.hs  = ~HP;
          oe.vs  = ~VP;
          oe.bn  = 1'b0;
          oe.rgb = '0;
        end
        check("sync", 64'({hs, vs}), 64'({oe.hs, oe.vs}));
        check("blankN", 64'(vgaBlankN), 64'(oe.bn));
        check("rgb", 64'({outRed, outGreen, outBlue}), 64'(oe.rgb));
        if (frameStart) begin
          if (lastFs >= 0) check("framePeriod", 64'(cyc - lastFs), 64'(FRAME));
          lastFs = cyc;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    {pixBus.inRed, pixBus.inGreen, pixBus.inBlue} = '0;
    repeat (3) @(posedge clk25);
    #1;
    resetChecks("reset");
    @(posedge clk25);
    #2;
    rstN  = 1'b1;
    monEn = 1'b1;

    runCycles(FRAME / 2);
    nextMode = 2'd3;
    runCycles(FRAME);
    nextMode = 2'd1;
    runCycles(FRAME);
    nextMode = 2'd2;
    runCycles(FRAME);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 599) == 0) nextMode = 2'($urandom_range(0, 3));
      stepCycle();
    end

    n = 0;
    while (!((cyc % HT) == HB + 15 && ((cyc / HT) % VT) == VB + 20) && n < 2 * FRAME) begin
      stepCycle();
      n++;
    end
    check("abortPosition", 64'(n < 2 * FRAME), 64'(1));
    @(posedge clk25);
    #3;
    rstN  = 1'b0;
    monEn = 1'b0;
    #1;
    resetChecks("abort");
    outQ.delete();
    combQ.delete();
    bufQ.delete();
    mMode  = 2'd0;
    lastFs = -1;
    repeat (2) @(posedge clk25);
    #2;
    rstN  = 1'b1;
    monEn = 1'b1;

    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * FRAME) begin
      stepCycle();
      if (frameStart) seen = 1'b1;
      else n++;
    end
    check("firstFrameAfterAbort", 64'(n), 64'(VB * HT + HB));
    runCycles(FRAME);

    @(negedge clk25);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
